// File: rtl/uart_core_param.sv
// Full-duplex UART with a compile-time divider, data width, parity and stop-bit count.
// The TX and RX state machines are fully independent; RX uses mid-bit sampling after a 2-flop synchroniser.
module uart_core_param #(
    parameter int unsigned CLK_DIV    = 16,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY_EN  = 0,
    parameter int unsigned PARITY_ODD = 0,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] i_tx_data,
    input  logic                 i_tx_ready,
    output logic                 o_tx_busy,
    output logic                 o_tx_data,
    input  logic                 i_rx_data,
    output logic [DATA_BITS-1:0] o_rx_data,
    output logic                 o_rx_valid,
    output logic                 o_rx_parity_err,
    output logic                 o_rx_frame_err
);

    localparam int unsigned CW = $clog2(CLK_DIV);
    localparam int unsigned BW = $clog2(DATA_BITS + 1);

    localparam logic [CW-1:0] CNT_LAST  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] CNT_HALF  = CW'(CLK_DIV / 2 - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
    localparam logic          PAR_EN    = (PARITY_EN != 0);
    localparam logic          PAR_ODD   = (PARITY_ODD != 0);

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {TxIdle, TxStart, TxData, TxParity, TxStop} tx_state_t;

    tx_state_t            tx_state;
    logic [CW-1:0]        tx_cnt;
    logic [BW-1:0]        tx_bit;
    logic [DATA_BITS-1:0] tx_shift;
    logic                 tx_par;
    logic                 tx_tick;

    assign tx_tick = (tx_cnt == CNT_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_state  <= TxIdle;
            tx_cnt    <= '0;
            tx_bit    <= '0;
            tx_shift  <= '0;
            tx_par    <= 1'b0;
            o_tx_data <= 1'b1;
            o_tx_busy <= 1'b0;
        end else begin
            if (tx_state != TxIdle) begin
                tx_cnt <= tx_tick ? '0 : tx_cnt + 1'b1;
            end
            case (tx_state)
                TxIdle: begin
                    if (i_tx_ready) begin
                        tx_shift  <= i_tx_data;
                        tx_par    <= (^i_tx_data) ^ PAR_ODD;
                        tx_cnt    <= '0;
                        tx_bit    <= '0;
                        o_tx_data <= 1'b0;
                        o_tx_busy <= 1'b1;
                        tx_state  <= TxStart;
                    end
                end
                TxStart: begin
                    if (tx_tick) begin
                        o_tx_data <= tx_shift[0];
                        tx_state  <= TxData;
                    end
                end
                TxData: begin
                    if (tx_tick) begin
                        if (tx_bit == BIT_LAST) begin
                            tx_bit <= '0;
                            if (PAR_EN) begin
                                o_tx_data <= tx_par;
                                tx_state  <= TxParity;
                            end else begin
                                o_tx_data <= 1'b1;
                                tx_state  <= TxStop;
                            end
                        end else begin
                            tx_bit    <= tx_bit + 1'b1;
                            tx_shift  <= tx_shift >> 1;
                            o_tx_data <= tx_shift[1];
                        end
                    end
                end
                TxParity: begin
                    if (tx_tick) begin
                        o_tx_data <= 1'b1;
                        tx_state  <= TxStop;
                    end
                end
                TxStop: begin
                    // tx_bit is reused here to count stop-bit periods
                    if (tx_tick) begin
                        if (tx_bit == STOP_LAST) begin
                            tx_bit    <= '0;
                            o_tx_busy <= 1'b0;
                            tx_state  <= TxIdle;
                        end else begin
                            tx_bit <= tx_bit + 1'b1;
                        end
                    end
                end
                default: begin
                    o_tx_data <= 1'b1;
                    o_tx_busy <= 1'b0;
                    tx_state  <= TxIdle;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    logic rx_meta;
    logic rx_s;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= i_rx_data;
            rx_s    <= rx_meta;
        end
    end

    typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxParity, RxStop, RxBreak} rx_state_t;

    rx_state_t            rx_state;
    logic [CW-1:0]        rx_cnt;
    logic [BW-1:0]        rx_bit;
    logic [DATA_BITS-1:0] rx_shift;
    logic                 rx_par;
    logic                 rx_perr;
    logic                 rx_tick;
    logic                 rx_half;

    assign rx_tick = (rx_cnt == CNT_LAST);
    assign rx_half = (rx_cnt == CNT_HALF);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_state        <= RxIdle;
            rx_cnt          <= '0;
            rx_bit          <= '0;
            rx_shift        <= '0;
            rx_par          <= 1'b0;
            rx_perr         <= 1'b0;
            o_rx_data       <= '0;
            o_rx_valid      <= 1'b0;
            o_rx_parity_err <= 1'b0;
            o_rx_frame_err  <= 1'b0;
        end else begin
            o_rx_valid <= 1'b0;
            case (rx_state)
                RxIdle: begin
                    rx_cnt <= '0;
                    if (!rx_s) begin
                        rx_state <= RxStart;
                    end
                end
                RxStart: begin
                    // Half a bit in: a line already back high was only a glitch
                    if (rx_half) begin
                        rx_cnt <= '0;
                        if (rx_s) begin
                            rx_state <= RxIdle;
                        end else begin
                            rx_bit   <= '0;
                            rx_par   <= 1'b0;
                            rx_state <= RxData;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RxData: begin
                    if (rx_tick) begin
                        rx_cnt   <= '0;
                        rx_shift <= {rx_s, rx_shift[DATA_BITS-1:1]};
                        rx_par   <= rx_par ^ rx_s;
                        if (rx_bit == BIT_LAST) begin
                            rx_bit   <= '0;
                            rx_perr  <= 1'b0;
                            rx_state <= PAR_EN ? RxParity : RxStop;
                        end else begin
                            rx_bit <= rx_bit + 1'b1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RxParity: begin
                    if (rx_tick) begin
                        rx_cnt   <= '0;
                        rx_perr  <= rx_s ^ rx_par ^ PAR_ODD;
                        rx_state <= RxStop;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RxStop: begin
                    if (rx_tick) begin
                        rx_cnt          <= '0;
                        o_rx_data       <= rx_shift;
                        o_rx_parity_err <= rx_perr;
                        o_rx_frame_err  <= ~rx_s;
                        o_rx_valid      <= 1'b1;
                        rx_state        <= rx_s ? RxIdle : RxBreak;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RxBreak: begin
                    rx_cnt <= '0;
                    if (rx_s) begin
                        rx_state <= RxIdle;
                    end
                end
                default: begin
                    rx_cnt   <= '0;
                    rx_state <= RxIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_core_param.sv
// Bench for uart_core_param: one no-parity instance and one even-parity instance, CLK_DIV=4, 8 data bits.
// Frames are built from the serial format rules and compared bit by bit / field by field.
module tb_uart_core_param;

    localparam int CD = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [7:0] txd_m, txd_p, rxd_m, rxd_p;
    logic rdy_m, rdy_p, busy_m, busy_p, tx_m, tx_p;
    logic drv_m, drv_p, lb_m, lb_p;
    logic val_m, val_p, pe_m, pe_p, fe_m, fe_p;

    uart_core_param #(
        .CLK_DIV(CD), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)
    ) dut (
        .clk(clk), .reset(reset),
        .i_tx_data(txd_m), .i_tx_ready(rdy_m), .o_tx_busy(busy_m), .o_tx_data(tx_m),
        .i_rx_data(lb_m ? tx_m : drv_m), .o_rx_data(rxd_m), .o_rx_valid(val_m),
        .o_rx_parity_err(pe_m), .o_rx_frame_err(fe_m)
    );

    uart_core_param #(
        .CLK_DIV(CD), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)
    ) dut_p (
        .clk(clk), .reset(reset),
        .i_tx_data(txd_p), .i_tx_ready(rdy_p), .o_tx_busy(busy_p), .o_tx_data(tx_p),
        .i_rx_data(lb_p ? tx_p : drv_p), .o_rx_data(rxd_p), .o_rx_valid(val_p),
        .o_rx_parity_err(pe_p), .o_rx_frame_err(fe_p)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Received-frame monitor, index 0 = plain instance, 1 = parity instance
    int         vcnt[2] = '{0, 0};
    int         vcyc[2] = '{0, 0};
    logic [7:0] vdata[2];
    logic       vperr[2];
    logic       vferr[2];

    always @(negedge clk) begin
        if (val_m) begin
            vcnt[0] <= vcnt[0] + 1; vcyc[0] <= cyc;
            vdata[0] <= rxd_m; vperr[0] <= pe_m; vferr[0] <= fe_m;
        end
        if (val_p) begin
            vcnt[1] <= vcnt[1] + 1; vcyc[1] <= cyc;
            vdata[1] <= rxd_p; vperr[1] <= pe_p; vferr[1] <= fe_p;
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    // Reference frame: start, 8 data LSB first, optional even parity (optionally inverted), stop
    logic fr[0:15];
    int   fr_len;

    task automatic build(input logic [7:0] d, input int pe, input logic flip, input logic stopv);
        fr[0] = 1'b0;
        for (int i = 0; i < 8; i++) fr[i + 1] = d[i];
        fr_len = 9;
        if (pe != 0) begin
            fr[9] = (^d) ^ flip;
            fr_len = 10;
        end
        fr[fr_len] = stopv;
        fr_len++;
    endtask

    task automatic set_tx(input int w, input logic [7:0] d, input logic r);
        if (w == 0) begin txd_m = d; rdy_m = r; end
        else begin txd_p = d; rdy_p = r; end
    endtask

    task automatic set_rx(input int w, input logic b);
        if (w == 0) drv_m = b;
        else drv_p = b;
    endtask

    function automatic logic [1:0] tx_state_of(input int w);
        return (w == 0) ? {busy_m, tx_m} : {busy_p, tx_p};
    endfunction

    // Transmit one byte and compare every cycle of the line; optionally poke i_tx_ready mid-frame
    task automatic check_tx(input int w, input logic [7:0] d, input logic poke);
        int seen;
        build(d, w, 1'b0, 1'b1);
        @(negedge clk); set_tx(w, d, 1'b1);
        for (int i = 0; i < fr_len * CD; i++) begin
            @(negedge clk);
            set_tx(w, ~d, poke && (i == 15));
            chk($sformatf("tx%0d %02h cyc%0d {busy,line}", w, d, i),
                32'(tx_state_of(w)), 32'({1'b1, fr[i / CD]}));
        end
        @(negedge clk); set_tx(w, ~d, 1'b0);
        chk($sformatf("tx%0d %02h idle after frame", w, d), 32'(tx_state_of(w)), 32'h1);
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (tx_state_of(w) != 2'b01) seen++;
        end
        chk($sformatf("tx%0d %02h no queued frame", w, d), 32'(seen), 32'd0);
    endtask

    // Drive one frame into the receiver and check the reported result and its timing
    task automatic rx_check(input int w, input logic [7:0] d, input logic flip, input logic stopv,
                            input logic [7:0] ed, input logic eperr, input logic eferr);
        int c0, start;
        c0 = vcnt[w];
        build(d, w, flip, stopv);
        @(negedge clk);
        start = cyc + 1;
        for (int b = 0; b < fr_len; b++) begin
            set_rx(w, fr[b]);
            repeat (CD) @(negedge clk);
        end
        set_rx(w, 1'b1);
        repeat (8) @(negedge clk);
        chk($sformatf("rx%0d %02h valid count", w, d), 32'(vcnt[w] - c0), 32'd1);
        chk($sformatf("rx%0d %02h data", w, d), 32'(vdata[w]), 32'(ed));
        chk($sformatf("rx%0d %02h parity_err", w, d), 32'(vperr[w]), 32'(eperr));
        chk($sformatf("rx%0d %02h frame_err", w, d), 32'(vferr[w]), 32'(eferr));
        chk($sformatf("rx%0d %02h valid cycle", w, d), 32'(vcyc[w] - start),
            32'((fr_len - 1) * CD + CD / 2 + 2));
    endtask

    typedef struct {
        int         w;
        logic [7:0] din;
        logic       flip;
        logic       stopv;
        logic [7:0] exp_data;
        logic       exp_perr;
        logic       exp_ferr;
    } rx_vec_t;

    rx_vec_t vecs[7];

    initial begin
        int c0;
        int w;
        logic [7:0] d;
        logic flip, stopv;

        vecs[0] = '{0, 8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
        vecs[1] = '{0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
        vecs[2] = '{0, 8'hFF, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};
        vecs[3] = '{0, 8'h3C, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1};
        vecs[4] = '{1, 8'h07, 1'b1, 1'b1, 8'h07, 1'b1, 1'b0};
        vecs[5] = '{1, 8'h81, 1'b0, 1'b1, 8'h81, 1'b0, 1'b0};
        vecs[6] = '{1, 8'hFE, 1'b0, 1'b0, 8'hFE, 1'b0, 1'b1};

        txd_m = 8'h00; txd_p = 8'h00; rdy_m = 1'b0; rdy_p = 1'b0;
        drv_m = 1'b1; drv_p = 1'b1; lb_m = 1'b0; lb_p = 1'b0;

        repeat (3) @(negedge clk);
        chk("reset tx line", 32'(tx_m), 32'd1);
        chk("reset tx busy", 32'(busy_m), 32'd0);
        chk("reset rx data", 32'(rxd_m), 32'd0);
        chk("reset rx valid", 32'(val_m), 32'd0);
        chk("reset rx flags", 32'({pe_m, fe_m}), 32'd0);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // TX basic, then with a mid-frame start request that must be ignored
        check_tx(0, 8'hF0, 1'b0);
        check_tx(0, 8'hF0, 1'b1);

        for (int i = 0; i < 7; i++) begin
            rx_check(vecs[i].w, vecs[i].din, vecs[i].flip, vecs[i].stopv,
                     vecs[i].exp_data, vecs[i].exp_perr, vecs[i].exp_ferr);
        end

        // Parity loopback: 8'h07 carries an even-parity bit of 1
        lb_p = 1'b1;
        c0 = vcnt[1];
        check_tx(1, 8'h07, 1'b0);
        chk("loop par count", 32'(vcnt[1] - c0), 32'd1);
        chk("loop par data", 32'(vdata[1]), 32'h07);
        chk("loop par flags", 32'({vperr[1], vferr[1]}), 32'd0);
        lb_p = 1'b0;

        // Held-low line: exactly one frame error, nothing more until a fresh start bit
        c0 = vcnt[0];
        @(negedge clk); drv_m = 1'b0;
        repeat (100) @(negedge clk);
        chk("break count", 32'(vcnt[0] - c0), 32'd1);
        chk("break data", 32'(vdata[0]), 32'h00);
        chk("break frame_err", 32'(vferr[0]), 32'd1);
        chk("break parity_err", 32'(vperr[0]), 32'd0);
        drv_m = 1'b1;
        repeat (20) @(negedge clk);
        chk("break no repeat", 32'(vcnt[0] - c0), 32'd1);
        rx_check(0, 8'h5A, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b0);

        // One-cycle glitch must not produce a frame or disturb the held result
        c0 = vcnt[0];
        @(negedge clk); drv_m = 1'b0;
        @(negedge clk); drv_m = 1'b1;
        repeat (20) @(negedge clk);
        chk("glitch no valid", 32'(vcnt[0] - c0), 32'd0);
        chk("glitch data held", 32'(rxd_m), 32'h5A);
        chk("glitch flags held", 32'({pe_m, fe_m}), 32'd0);

        // Back-to-back with i_tx_ready held: exactly one idle-high cycle between frames
        @(negedge clk); set_tx(0, 8'h55, 1'b1);
        repeat (40) @(negedge clk);
        @(negedge clk);
        chk("b2b gap {busy,line}", 32'(tx_state_of(0)), 32'h1);
        @(negedge clk);
        chk("b2b restart {busy,line}", 32'(tx_state_of(0)), 32'h2);
        set_tx(0, 8'h55, 1'b0);
        repeat (45) @(negedge clk);
        chk("b2b end busy", 32'(busy_m), 32'd0);

        // Asynchronous reset in the middle of a loopback frame
        lb_m = 1'b1;
        c0 = vcnt[0];
        @(negedge clk); set_tx(0, 8'h96, 1'b1);
        @(negedge clk); set_tx(0, 8'h96, 1'b0);
        repeat (20) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("async rst tx line", 32'(tx_m), 32'd1);
        chk("async rst tx busy", 32'(busy_m), 32'd0);
        chk("async rst rx data", 32'(rxd_m), 32'd0);
        chk("async rst rx valid", 32'(val_m), 32'd0);
        @(negedge clk);
        @(negedge clk); reset = 1'b0;
        repeat (10) @(negedge clk);
        chk("rst aborted frame silent", 32'(vcnt[0] - c0), 32'd0);
        c0 = vcnt[0];
        check_tx(0, 8'h3C, 1'b0);
        chk("post-rst loop count", 32'(vcnt[0] - c0), 32'd1);
        chk("post-rst loop data", 32'(vdata[0]), 32'h3C);
        chk("post-rst loop flags", 32'({vperr[0], vferr[0]}), 32'd0);
        lb_m = 1'b0;

        // Randomised frames against the frame model
        for (int i = 0; i < 16; i++) begin
            w = int'($urandom_range(0, 1));
            d = 8'($urandom);
            flip = 1'($urandom_range(0, 1));
            stopv = ($urandom_range(0, 3) != 0);
            rx_check(w, d, flip, stopv, d, (w == 1) ? flip : 1'b0, ~stopv);
        end
        for (int i = 0; i < 4; i++) begin
            w = int'($urandom_range(0, 1));
            d = 8'($urandom);
            check_tx(w, d, 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
